// File: rtl/packet_disassembler_if.sv
// Packet-stream bundle between the TERC4 decode front end and the data island packet disassembler.
// The source side drives the island payload and the disassembler side returns the decoded packet.
interface packet_disassembler_if #(
    parameter int ERR_CNT_WIDTH = 16
) ();
    logic                     data_island_period;
    logic [8:0]               packet_data;
    logic [23:0]              header;
    logic [55:0]              sub_0;
    logic [55:0]              sub_1;
    logic [55:0]              sub_2;
    logic [55:0]              sub_3;
    logic                     packet_valid;
    logic                     header_ecc_err;
    logic [3:0]               sub_ecc_err;
    logic [ERR_CNT_WIDTH-1:0] ecc_err_count;
    logic [4:0]               counter;

    modport master (
        output data_island_period, packet_data,
        input  header, sub_0, sub_1, sub_2, sub_3, packet_valid,
        input  header_ecc_err, sub_ecc_err, ecc_err_count, counter
    );

    modport slave (
        input  data_island_period, packet_data,
        output header, sub_0, sub_1, sub_2, sub_3, packet_valid,
        output header_ecc_err, sub_ecc_err, ecc_err_count, counter
    );
endinterface

// File: rtl/packet_disassembler.sv
// HDMI sink data island packet disassembler: rebuilds header + 4 subpackets and checks all five BCH parities.
// Build option PACKET_DISASSEMBLER_DROP_ERR_EN suppresses output update/strobe for packets with ECC errors.
module packet_disassembler #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    packet_disassembler_if.slave bus
);
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    logic [4:0]               counter_q, counter_d;
    logic [23:0]              hdr_sr_q, hdr_sr_d;
    logic [6:0]               hdr_par_q, hdr_par_d;
    logic [7:0]               hdr_ecc_q, hdr_ecc_d;
    logic [3:0][55:0]         sub_sr_q, sub_sr_d;
    logic [3:0][5:0]          sub_par_q, sub_par_d;
    logic [3:0][7:0]          sub_ecc_q, sub_ecc_d;
    logic [23:0]              header_q, header_d;
    logic [3:0][55:0]         sub_q, sub_d;
    logic                     valid_q, valid_d;
    logic                     hdr_err_q, hdr_err_d;
    logic [3:0]               sub_err_q, sub_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    logic            dip;
    logic [8:0]      pd;
    logic            complete;
    logic            any_err;
    logic            hdr_err_c;
    logic [3:0]      sub_err_c;
    logic [7:0]      sbase;
    logic [2:0]      hidx;
    logic [2:0]      sidx;

    assign dip = bus.data_island_period;
    assign pd  = bus.packet_data;

    always_comb begin
        counter_d = counter_q;
        hdr_sr_d  = hdr_sr_q;
        hdr_par_d = hdr_par_q;
        hdr_ecc_d = hdr_ecc_q;
        sub_sr_d  = sub_sr_q;
        sub_par_d = sub_par_q;
        sub_ecc_d = sub_ecc_q;
        header_d  = header_q;
        sub_d     = sub_q;
        valid_d   = 1'b0;
        hdr_err_d = hdr_err_q;
        sub_err_d = sub_err_q;
        err_cnt_d = err_cnt_q;
        sbase     = 8'h00;
        hidx      = 3'(counter_q - 5'd24);
        sidx      = 3'({counter_q - 5'd28, 1'b0});

        complete  = dip && (counter_q == 5'd31);
        // The last parity bits arrive on the completion cycle itself, so they are compared straight off the bus.
        hdr_err_c = ({pd[0], hdr_par_q} != hdr_ecc_q);
        for (int i = 0; i < 4; i++)
            sub_err_c[i] = ({pd[5+i], pd[1+i], sub_par_q[i]} != sub_ecc_q[i]);
        any_err   = hdr_err_c || (|sub_err_c);

        if (!dip) begin
            counter_d = '0;
            hdr_sr_d  = '0;
            hdr_par_d = '0;
            hdr_ecc_d = '0;
            sub_sr_d  = '0;
            sub_par_d = '0;
            sub_ecc_d = '0;
        end else begin
            counter_d = counter_q + 5'd1;
            if (counter_q < 5'd24) begin
                hdr_sr_d[counter_q] = pd[0];
                hdr_ecc_d = ecc_step((counter_q == 5'd0) ? 8'h00 : hdr_ecc_q, pd[0]);
            end else if (counter_q < 5'd31) begin
                hdr_par_d[hidx] = pd[0];
            end
            for (int i = 0; i < 4; i++) begin
                if (counter_q < 5'd28) begin
                    sbase = (counter_q == 5'd0) ? 8'h00 : sub_ecc_q[i];
                    sub_sr_d[i][{counter_q, 1'b0}]       = pd[1+i];
                    sub_sr_d[i][{counter_q, 1'b0} + 6'd1] = pd[5+i];
                    sub_ecc_d[i] = ecc_step(ecc_step(sbase, pd[1+i]), pd[5+i]);
                end else if (counter_q < 5'd31) begin
                    sub_par_d[i][sidx]        = pd[1+i];
                    sub_par_d[i][sidx + 3'd1] = pd[5+i];
                end
            end
        end

        if (complete) begin
            hdr_err_d = hdr_err_c;
            sub_err_d = sub_err_c;
            if (any_err && (err_cnt_q != '1))
                err_cnt_d = err_cnt_q + 1'b1;
`ifdef PACKET_DISASSEMBLER_DROP_ERR_EN
            if (!any_err) begin
                header_d = hdr_sr_q;
                sub_d    = sub_sr_q;
                valid_d  = 1'b1;
            end
`else
            header_d = hdr_sr_q;
            sub_d    = sub_sr_q;
            valid_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
            hdr_sr_q  <= '0;
            hdr_par_q <= '0;
            hdr_ecc_q <= '0;
            sub_sr_q  <= '0;
            sub_par_q <= '0;
            sub_ecc_q <= '0;
            header_q  <= '0;
            sub_q     <= '0;
            valid_q   <= 1'b0;
            hdr_err_q <= 1'b0;
            sub_err_q <= '0;
            err_cnt_q <= '0;
        end else begin
            counter_q <= counter_d;
            hdr_sr_q  <= hdr_sr_d;
            hdr_par_q <= hdr_par_d;
            hdr_ecc_q <= hdr_ecc_d;
            sub_sr_q  <= sub_sr_d;
            sub_par_q <= sub_par_d;
            sub_ecc_q <= sub_ecc_d;
            header_q  <= header_d;
            sub_q     <= sub_d;
            valid_q   <= valid_d;
            hdr_err_q <= hdr_err_d;
            sub_err_q <= sub_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.header         = header_q;
    assign bus.sub_0          = sub_q[0];
    assign bus.sub_1          = sub_q[1];
    assign bus.sub_2          = sub_q[2];
    assign bus.sub_3          = sub_q[3];
    assign bus.packet_valid   = valid_q;
    assign bus.header_ecc_err = hdr_err_q;
    assign bus.sub_ecc_err    = sub_err_q;
    assign bus.ecc_err_count  = err_cnt_q;
    assign bus.counter        = counter_q;
endmodule

// File: tb/tb_packet_disassembler.sv
// Scoreboard bench for packet_disassembler: directed packets are queued as expected results and
// checked by an independent monitor whenever packet_valid strobes.
module tb_packet_disassembler;
`ifdef PACKET_DISASSEMBLER_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    packet_disassembler_if #(.ERR_CNT_WIDTH(16)) bus ();

    packet_disassembler #(.ERR_CNT_WIDTH(16)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [23:0]      hdr;
        logic [3:0][55:0] s;
        logic             he;
        logic [3:0]       se;
        logic [15:0]      cnt;
        logic [31:0]      cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    logic [15:0] exp_cnt  = 0;
    logic [23:0] last_hdr = 0;
    logic [3:0][55:0] last_s = '0;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ecc_of(input logic [63:0] d, input int n);
        logic [7:0] e;
        logic fb;
        e = 8'h00;
        for (int j = 0; j < n; j++) begin
            fb = e[0] ^ d[j];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Streams n pixels of a packet; only full 32-pixel packets produce an expected result.
    task automatic send(input logic [23:0] hdr, input logic [3:0][55:0] s,
                        input logic [3:0][55:0] flip, input int n, input logic [3:0] exp_se);
        logic [31:0]      hfull;
        logic [3:0][63:0] blk;
        logic [3:0][55:0] data;
        exp_t             e;
        hfull = {ecc_of({40'h0, hdr}, 24), hdr};
        for (int i = 0; i < 4; i++) begin
            data[i] = s[i] ^ flip[i];
            blk[i]  = {ecc_of({8'h0, s[i]}, 56), data[i]};
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk_pixel);
            check("counter", 64'(bus.counter), 64'(k));
            if (k == 0 && n == 32) begin
                if (exp_se != 4'b0) exp_cnt = exp_cnt + 16'd1;
                if (!(DROP && exp_se != 4'b0)) begin
                    e.hdr = hdr; e.s = data; e.he = 1'b0; e.se = exp_se;
                    e.cnt = exp_cnt; e.cyc = cyc + 32;
                    sb_q.push_back(e);
                    last_hdr = hdr;
                    last_s   = data;
                end
            end
            bus.data_island_period = 1'b1;
            bus.packet_data[0] = hfull[k];
            for (int i = 0; i < 4; i++) begin
                bus.packet_data[1+i] = blk[i][2*k];
                bus.packet_data[5+i] = blk[i][2*k+1];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_pixel);
            bus.data_island_period = 1'b0;
            bus.packet_data = '0;
        end
    endtask

    always @(negedge clk_pixel) begin : monitor
        exp_t e;
        if (bus.packet_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_strobe: got packet_valid=1 header=%h expected no strobe", bus.header);
            end else begin
                e = sb_q.pop_front();
                check("header", 64'(bus.header), 64'(e.hdr));
                check("sub_0", 64'(bus.sub_0), 64'(e.s[0]));
                check("sub_1", 64'(bus.sub_1), 64'(e.s[1]));
                check("sub_2", 64'(bus.sub_2), 64'(e.s[2]));
                check("sub_3", 64'(bus.sub_3), 64'(e.s[3]));
                check("header_ecc_err", 64'(bus.header_ecc_err), 64'(e.he));
                check("sub_ecc_err", 64'(bus.sub_ecc_err), 64'(e.se));
                check("ecc_err_count", 64'(bus.ecc_err_count), 64'(e.cnt));
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish within 100000 time units, expected completion");
        $fatal(1, "timeout");
    end

    logic [3:0][55:0] S_AVI, S_AUD, ZERO, FLIP2;

    initial begin
        S_AVI = {56'h13579BDF02468A, 56'h00A5A55A5AFF01, 56'hFEDCBA98765432, 56'h0123456789ABCD};
        S_AUD = {56'h0F0F0F0F0F0F0F, 56'h80000000000001, 56'h5555AAAA5555AA, 56'h00000000C0FFEE};
        ZERO  = '0;
        FLIP2 = '0;
        FLIP2[2][17] = 1'b1;
        bus.data_island_period = 1'b0;
        bus.packet_data = '0;

        repeat (2) @(negedge clk_pixel);
        check("rst_counter", 64'(bus.counter), 64'h0);
        check("rst_header", 64'(bus.header), 64'h0);
        check("rst_sub_0", 64'(bus.sub_0), 64'h0);
        check("rst_valid", 64'(bus.packet_valid), 64'h0);
        check("rst_errs", 64'({bus.header_ecc_err, bus.sub_ecc_err}), 64'h0);
        check("rst_count", 64'(bus.ecc_err_count), 64'h0);
        reset_n = 1'b1;

        // Null packet, then a clean AVI InfoFrame
        send(24'h000000, ZERO, ZERO, 32, 4'b0000);
        idle(3);
        send(24'h0D0282, S_AVI, ZERO, 32, 4'b0000);
        idle(3);

        // Corrupted subpacket 2
        send(24'h0D0282, S_AVI, FLIP2, 32, 4'b0100);
        @(negedge clk_pixel);
        bus.data_island_period = 1'b0;
        check("corrupt_hdr_err", 64'(bus.header_ecc_err), 64'h0);
        check("corrupt_sub_err", 64'(bus.sub_ecc_err), 64'h4);
        check("corrupt_count", 64'(bus.ecc_err_count), 64'h1);
        check("corrupt_valid", 64'(bus.packet_valid), DROP ? 64'h0 : 64'h1);
        check("corrupt_sub_2", 64'(bus.sub_2), 64'(DROP ? S_AVI[2] : (S_AVI[2] ^ FLIP2[2])));
        idle(2);

        // Abort at counter 15, then a full audio packet
        send(24'h0A0184, S_AUD, ZERO, 15, 4'b0000);
        idle(3);
        check("abort_counter", 64'(bus.counter), 64'h0);
        check("abort_header", 64'(bus.header), 64'(last_hdr));
        check("abort_sub_2", 64'(bus.sub_2), 64'(last_s[2]));
        send(24'h0A0184, S_AUD, ZERO, 32, 4'b0000);
        idle(3);

        // Back-to-back packets
        send(24'h0D0282, S_AVI, ZERO, 32, 4'b0000);
        send(24'h0A0184, S_AUD, ZERO, 32, 4'b0000);
        idle(3);

        // Reset mid-packet at counter 20
        send(24'h0D0282, S_AVI, ZERO, 21, 4'b0000);
        check("pre_reset_counter", 64'(bus.counter), 64'd20);
        #2 reset_n = 1'b0;
        #1;
        check("arst_counter", 64'(bus.counter), 64'h0);
        check("arst_header", 64'(bus.header), 64'h0);
        check("arst_sub_3", 64'(bus.sub_3), 64'h0);
        check("arst_errs", 64'({bus.header_ecc_err, bus.sub_ecc_err}), 64'h0);
        check("arst_count", 64'(bus.ecc_err_count), 64'h0);
        exp_cnt = 16'd0;
        @(negedge clk_pixel);
        bus.data_island_period = 1'b0;
        bus.packet_data = '0;
        reset_n = 1'b1;
        idle(2);
        send(24'h0A0184, S_AUD, ZERO, 32, 4'b0000);
        idle(3);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/packet_disassembler.md
Name: packet_disassembler

Overview:
HDMI sink-side data island packet disassembler, the receive counterpart of the TX packet assembler. Consumes the 9-bit per-pixel packet stream recovered from TERC4-decoded TMDS channels 0–2 during data island periods. Reassembles the 24-bit header and four 56-bit subpackets, and checks all five BCH ECC parity bytes. Presents each completed packet with a one-cycle valid strobe and per-block error flags to downstream InfoFrame/audio parsers.

Parameters:
ERR_CNT_WIDTH, 16, width of saturating ECC error packet counter.

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
data_island_period  input  1  high while packet_data carries data island payload (excludes guard bands)
packet_data  input  9  [0]=header/BCH4 bit; [4:1]=bit 2k of BCH blocks 3..0 (bit i+1 = block i); [8:5]=bit 2k+1 of blocks 3..0
header  output  24  last completed packet header (HB2,HB1,HB0 = [23:16],[15:8],[7:0])
sub_0..sub_3  output  56 each  last completed subpacket data, parity stripped
packet_valid  output  1  one-cycle strobe: header/sub_*/err flags updated
header_ecc_err  output  1  received BCH4 parity != computed, for this packet
sub_ecc_err  output  4  bit i = subpacket i parity mismatch
ecc_err_count  output  ERR_CNT_WIDTH  saturating count of packets with any ECC error
counter  output  5  pixel index within current packet (0..31)

Behaviour:
- Reset (async, reset_n=0): counter=0; header, sub_*, all shift/parity registers = 0; packet_valid=0; header_ecc_err=0; sub_ecc_err=0; ecc_err_count=0.
- counter: increments by 1 each cycle with data_island_period=1, wraps 31->0. Forced to 0 on any cycle with data_island_period=0.
- Bit placement at counter=k: header bit k = packet_data[0] for k<24; received BCH4 parity bit k-24 for k>=24. Block i bit 2k = packet_data[1+i], bit 2k+1 = packet_data[5+i]; k<28 is data, k>=28 is received parity bits 2k-56, 2k-55.
- ECC: per-bit update next(e,b) = (e>>1) ^ ((e[0]^b) ? 8'h83 : 8'h00), LSB-first, initial 0.
  - Header: one bit per cycle for k<24.
  - Subpackets: two bits per cycle (bit 2k, then 2k+1) for k<28.
  - Computed parity held constant for k>=24 (header) and k>=28 (subpackets).
- Completion: on the rising edge where data_island_period=1 and counter=31, the following all take effect together, so packet_valid is high for exactly the next cycle:
  - header, sub_* load the assembled data;
  - error flags load (computed vs received parity, received bits taken combinationally from this cycle's packet_data);
  - packet_valid=1.
- Latency: packet_valid 32 cycles after the first data_island_period=1 cycle of a packet.
- Output hold: header/sub_*/err flags hold until the next completion. packet_valid=0 on all other cycles.
- Back-to-back packets: wrap 31->0 with data_island_period held high. ECC accumulators restart at 0 on counter=0 with no bubble.
- Abort: data_island_period falls before counter=31. Partial packet discarded: no packet_valid, outputs unchanged, accumulators and counter cleared. Next island starts at counter=0.
- Reset mid-packet: immediate clear as above; no strobe.
- ecc_err_count: +1 on each completion with (header_ecc_err|sub_ecc_err) nonzero. Saturates at all-ones.

Optional Feature:
PACKET_DISASSEMBLER_DROP_ERR_EN
- Defined: completions with any ECC error leave header/sub_* unchanged and do not pulse packet_valid. Error flags and ecc_err_count still update on that edge.
- Undefined: every completion updates outputs and pulses packet_valid regardless of errors.

Test Plan:
- Null packet (header 24'h000000, subs 0, parity 0) streamed 32 cycles -> packet_valid at cycle 32, header=0, all err=0, ecc_err_count=0.
- AVI InfoFrame header 24'h0D0282 with random subs, parity from bench next() model -> header=24'h0D0282, sub_* match, no errors.
- Same packet with sub_2 data bit 17 flipped after parity generation -> sub_ecc_err=4'b0100, header_ecc_err=0, ecc_err_count=1. Under DROP_ERR_EN: no packet_valid, outputs keep previous packet.
- data_island_period dropped at counter=15, then a full valid packet -> no strobe for the aborted one; second packet correct with counter restarting at 0.
- Two packets back-to-back (64 cycles high) -> two packet_valid pulses 32 cycles apart, second packet's ECC unaffected by the first.
- reset_n pulsed low at counter=20 -> all outputs 0 asynchronously; a subsequent full packet decodes correctly.
